piso_tx: RTL and testbench

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_pkg.sv | 13 +
 rtl/piso_tx_if.sv | 35 +++
 rtl/piso_tx_bit_counter.sv | 27 ++
 rtl/piso_tx.sv | 94 +++++++++
 tb/tb_piso_tx.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter:
// FSM state encodings and the bit-order selector values.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  localparam bit ORDER_MSB_FIRST = 1'b1;
  localparam bit ORDER_LSB_FIRST = 1'b0;

endpackage

// File: rtl/piso_tx_if.sv
// Load handshake and serial output bundle for piso_tx.
// The producer side uses the master modport and the transmitter uses the slave modport.
interface piso_tx_if #(
  parameter int N = 8
);

  logic         load_valid;
  logic         load_ready;
  logic [N-1:0] load_data;
  logic         sout;
  logic         sout_valid;
  logic         last;
  logic         busy;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready,
    input  sout,
    input  sout_valid,
    input  last,
    input  busy
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready,
    output sout,
    output sout_valid,
    output last,
    output busy
  );

endinterface

// File: rtl/piso_tx_bit_counter.sv
// Saturating up-counter that tracks the position of the bit currently on sout.
// It stops at MAX, so it can never run past the final bit of a word.
module bit_counter #(
  parameter  int MAX = 7,
  localparam int W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         at_max
);

  assign at_max = (count == W'(MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts one N-bit word per valid/ready
// handshake and sends it out one bit per cycle, MSB or LSB first.
module piso_tx
  import piso_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic       clk,
  input  logic       rst,
  piso_tx_if.slave   bus
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  piso_state_t   state;
  piso_state_t   state_next;
  logic [N-1:0]  shreg;
  logic [CW-1:0] count;
  logic          at_max;
  logic          transfer;
  logic          shifting;
  logic          out_bit;

  assign shifting = (state == SHIFT);
  assign transfer = bus.load_valid && bus.load_ready;
  assign out_bit  = MSB_FIRST ? shreg[N-1] : shreg[0];

  bit_counter #(
    .MAX (N - 1)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (transfer),
    .enable (shifting),
    .count  (count),
    .at_max (at_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // load_ready is masked by rst so a word offered during reset is never taken
  always_comb begin
    state_next     = state;
    bus.load_ready = 1'b0;
    bus.sout       = 1'b0;
    bus.sout_valid = 1'b0;
    bus.last       = 1'b0;
    bus.busy       = 1'b0;
    case (state)
      IDLE: begin
        bus.load_ready = !rst;
        if (bus.load_valid && !rst) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        bus.sout       = out_bit;
        bus.sout_valid = 1'b1;
        bus.busy       = 1'b1;
        bus.last       = (count == LAST_IDX);
        if (at_max) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The register shifts toward whichever end feeds sout
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
    end else if (transfer) begin
      shreg <= bus.load_data;
    end else if (shifting) begin
      if (MSB_FIRST) begin
        shreg <= {shreg[N-2:0], 1'b0};
      end else begin
        shreg <= {1'b0, shreg[N-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed testbench for piso_tx: an 8-bit MSB-first instance and a
// 10-bit LSB-first instance share clock and reset.
module tb_piso_tx;
  import piso_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  piso_tx_if #(.N(8))  bus8 ();
  piso_tx_if #(.N(10)) bus10 ();

  piso_tx #(
    .N         (8),
    .MSB_FIRST (ORDER_MSB_FIRST)
  ) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  piso_tx #(
    .N         (10),
    .MSB_FIRST (ORDER_LSB_FIRST)
  ) dut10 (
    .clk (clk),
    .rst (rst),
    .bus (bus10.slave)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst              = 1'b1;
    bus8.load_valid  = 1'b0;
    bus8.load_data   = '0;
    bus10.load_valid = 1'b0;
    bus10.load_data  = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus8.load_ready, bus8.sout, bus8.sout_valid, bus8.last, bus8.busy} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset8_outputs: got %b expected 00000",
               {bus8.load_ready, bus8.sout, bus8.sout_valid, bus8.last, bus8.busy});
    end
    checks++;
    if ({bus10.load_ready, bus10.sout, bus10.sout_valid, bus10.last, bus10.busy} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset10_outputs: got %b expected 00000",
               {bus10.load_ready, bus10.sout, bus10.sout_valid, bus10.last, bus10.busy});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus8.load_ready, bus10.load_ready} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL ready_after_reset: got %b expected 11", {bus8.load_ready, bus10.load_ready});
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] w;
    logic [3:0] got;
    logic [3:0] exp;
    w = 8'hA5;
    @(negedge clk);
    bus8.load_valid = 1'b1;
    bus8.load_data  = w;
    @(negedge clk);
    bus8.load_valid = 1'b0;
    bus8.load_data  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      got = {bus8.sout, bus8.sout_valid, bus8.busy, bus8.last};
      exp = {w[7-i], 1'b1, 1'b1, (i == 7)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL a5_bit%0d: got %b expected %b (sout,valid,busy,last)", i, got, exp);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({bus8.sout_valid, bus8.busy, bus8.last, bus8.load_ready} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL a5_idle_after: got %b expected 0001",
               {bus8.sout_valid, bus8.busy, bus8.last, bus8.load_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0;
    logic [7:0] w1;
    logic [3:0] got;
    logic [3:0] exp;
    w0 = 8'h3C;
    w1 = 8'hC3;
    @(negedge clk);
    bus8.load_valid = 1'b1;
    bus8.load_data  = w0;
    @(negedge clk);
    bus8.load_data = w1;
    #1;
    checks++;
    if (bus8.load_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_ready_while_busy: got %b expected 0", bus8.load_ready);
    end
    for (int i = 0; i < 8; i++) begin
      got = {bus8.sout, bus8.sout_valid, bus8.busy, bus8.last};
      exp = {w0[7-i], 1'b1, 1'b1, (i == 7)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL b2b_w0_bit%0d: got %b expected %b (sout,valid,busy,last)", i, got, exp);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({bus8.sout_valid, bus8.load_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL b2b_gap_cycle: got %b expected 01 (valid,ready)", {bus8.sout_valid, bus8.load_ready});
    end
    @(negedge clk);
    bus8.load_valid = 1'b0;
    bus8.load_data  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      got = {bus8.sout, bus8.sout_valid, bus8.busy, bus8.last};
      exp = {w1[7-i], 1'b1, 1'b1, (i == 7)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL b2b_w1_bit%0d: got %b expected %b (sout,valid,busy,last)", i, got, exp);
      end
      @(negedge clk);
    end
    checks++;
    if ({bus8.sout_valid, bus8.busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL b2b_idle_after: got %b expected 00", {bus8.sout_valid, bus8.busy});
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    logic [3:0] got;
    logic [3:0] exp;
    w = 8'hFF;
    @(negedge clk);
    bus8.load_valid = 1'b1;
    bus8.load_data  = w;
    @(negedge clk);
    bus8.load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      got = {bus8.sout, bus8.sout_valid, bus8.busy, bus8.last};
      exp = {w[7-i], 1'b1, 1'b1, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL ff_bit%0d: got %b expected %b (sout,valid,busy,last)", i, got, exp);
      end
      @(negedge clk);
    end
    checks++;
    if ({bus8.sout, bus8.sout_valid} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL ff_bit3: got %b expected 11 (sout,valid)", {bus8.sout, bus8.sout_valid});
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus8.load_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_during_rst: got %b expected 0", bus8.load_ready);
    end
    @(negedge clk);
    checks++;
    if ({bus8.sout_valid, bus8.busy, bus8.sout} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got %b expected 000 (valid,busy,sout)",
               {bus8.sout_valid, bus8.busy, bus8.sout});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus8.load_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_abort: got %b expected 1", bus8.load_ready);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bus8.sout_valid, bus8.busy} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL abort_quiet%0d: got %b expected 00", i, {bus8.sout_valid, bus8.busy});
      end
    end
  endtask

  task automatic test_ignore_while_busy();
    logic [7:0] w;
    logic [3:0] got;
    logic [3:0] exp;
    w = 8'hF0;
    @(negedge clk);
    bus8.load_valid = 1'b1;
    bus8.load_data  = w;
    @(negedge clk);
    bus8.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = {bus8.sout, bus8.sout_valid, bus8.busy, bus8.last};
      exp = {w[7-i], 1'b1, 1'b1, (i == 7)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL f0_bit%0d: got %b expected %b (sout,valid,busy,last)", i, got, exp);
      end
      if (i == 2) begin
        bus8.load_valid = 1'b1;
        bus8.load_data  = 8'h00;
        #1;
        checks++;
        if (bus8.load_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL f0_ready_busy: got %b expected 0", bus8.load_ready);
        end
      end
      if (i == 3) begin
        bus8.load_valid = 1'b0;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({bus8.sout_valid, bus8.busy} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL f0_no_extra%0d: got %b expected 00", i, {bus8.sout_valid, bus8.busy});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lsb_first();
    logic [9:0] w;
    logic [3:0] got;
    logic [3:0] exp;
    w = 10'h201;
    @(negedge clk);
    bus10.load_valid = 1'b1;
    bus10.load_data  = w;
    @(negedge clk);
    bus10.load_valid = 1'b0;
    bus10.load_data  = '0;
    for (int i = 0; i < 10; i++) begin
      got = {bus10.sout, bus10.sout_valid, bus10.busy, bus10.last};
      exp = {w[i], 1'b1, 1'b1, (i == 9)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL lsb_bit%0d: got %b expected %b (sout,valid,busy,last)", i, got, exp);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({bus10.sout_valid, bus10.busy, bus10.load_ready} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL lsb_idle_after: got %b expected 001",
               {bus10.sout_valid, bus10.busy, bus10.load_ready});
    end
  endtask

  task automatic test_reset_with_transfer();
    @(negedge clk);
    rst             = 1'b1;
    bus8.load_valid = 1'b1;
    bus8.load_data  = 8'hA5;
    #1;
    checks++;
    if (bus8.load_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_xfer_ready: got %b expected 0", bus8.load_ready);
    end
    @(negedge clk);
    rst             = 1'b0;
    bus8.load_valid = 1'b0;
    #1;
    checks++;
    if ({bus8.sout_valid, bus8.busy, bus8.load_ready} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL rst_xfer_idle: got %b expected 001 (valid,busy,ready)",
               {bus8.sout_valid, bus8.busy, bus8.load_ready});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus8.sout_valid, bus8.busy} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL rst_xfer_quiet%0d: got %b expected 00", i, {bus8.sout_valid, bus8.busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_back_to_back();
    test_reset_mid_word();
    test_ignore_while_busy();
    test_lsb_first();
    test_reset_with_transfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
